// File: rtl/max7219_chain_tx.sv
// Daisy-chain MAX7219 frame transmitter: shifts N_DEV 16-bit frames
// in one CS-low window, then raises CS so all devices latch together.
module max7219_chain_tx #(
  parameter int N_DEV      = 4,
  parameter int HALF_TICKS = 1
) (
  input  logic                 clk_spi,
  input  logic                 _rst,
  input  logic                 str,
  input  logic [16*N_DEV-1:0]  frames,
  output logic                 busy,
  output logic                 done,
  output logic                 CS,
  output logic                 CLK,
  output logic                 Din
);

  localparam int B  = 16 * N_DEV;
  localparam int BW = $clog2(B);
  localparam int TW = (HALF_TICKS > 1) ? $clog2(HALF_TICKS) : 1;

  localparam logic [BW-1:0] BLAST = BW'(B - 1);
  localparam logic [TW-1:0] TLAST = TW'(HALF_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    HOLD,
    GAP
  } state_t;

  state_t          st;
  logic [B-1:0]    sr;
  logic [BW-1:0]   bit_cnt;
  logic [TW-1:0]   tick;
  logic            tick_end;

  assign tick_end = (tick == TLAST);

  // sr holds the bits still to send, MSB next; Din already carries the
  // current bit, so capture stores frames pre-shifted by one.
  always_ff @(posedge clk_spi or negedge _rst) begin
    if (!_rst) begin
      st      <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      tick    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      CS      <= 1'b1;
      CLK     <= 1'b0;
      Din     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st)
        IDLE: begin
          if (str) begin
            sr      <= {frames[B-2:0], 1'b0};
            Din     <= frames[B-1];
            CS      <= 1'b0;
            CLK     <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
            tick    <= '0;
            st      <= LOW;
          end
        end
        LOW: begin
          if (tick_end) begin
            tick <= '0;
            CLK  <= 1'b1;
            st   <= HIGH;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        HIGH: begin
          if (tick_end) begin
            tick <= '0;
            CLK  <= 1'b0;
            if (bit_cnt == BLAST) begin
              Din <= 1'b0;
              st  <= HOLD;
            end else begin
              Din     <= sr[B-1];
              sr      <= {sr[B-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
              st      <= LOW;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        HOLD: begin
          if (tick_end) begin
            tick <= '0;
            CS   <= 1'b1;
            st   <= GAP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        GAP: begin
          if (tick_end) begin
            tick <= '0;
            busy <= 1'b0;
            done <= 1'b1;
            st   <= IDLE;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
